// File: rtl/bcd_digit_encoder_if.sv
// Start/busy/done handshake bundle between the timer counters
// and the binary-to-BCD digit encoder.
interface bcd_digit_encoder_if #(
  parameter int BIN_WIDTH  = 14,
  parameter int NUM_DIGITS = 4
);

  logic                    Start;
  logic [BIN_WIDTH-1:0]    BinaryIn;
  logic                    Busy;
  logic                    Done;
  logic [4*NUM_DIGITS-1:0] BcdOut;
  logic                    Overflow;

  // Timer side: requests conversions, reads results.
  modport master (
    output Start,
    output BinaryIn,
    input  Busy,
    input  Done,
    input  BcdOut,
    input  Overflow
  );

  // Encoder side: accepts requests, publishes results.
  modport slave (
    input  Start,
    input  BinaryIn,
    output Busy,
    output Done,
    output BcdOut,
    output Overflow
  );

endinterface

// File: rtl/bcd_digit_encoder.sv
// Sequential shift-add-3 binary-to-BCD converter, one bit per clock.
// Results saturate to all nines when the input exceeds the digit range.
module bcd_digit_encoder #(
  parameter int BIN_WIDTH  = 14,
  parameter int NUM_DIGITS = 4
) (
  input logic          clock,
  input logic          reset,
  bcd_digit_encoder_if.slave bus
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(BIN_WIDTH + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  localparam logic [63:0]   MAX_VAL = pow10(NUM_DIGITS) - 64'd1;
  localparam logic [DW-1:0] NINES   = {NUM_DIGITS{4'h9}};
  localparam logic [CW-1:0] LAST    = CW'(BIN_WIDTH - 1);

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e               state_q, state_d;
  logic [BIN_WIDTH-1:0] sh_q, sh_d;
  logic [DW-1:0]        scr_q, scr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ovf_flag_q, ovf_flag_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [DW-1:0]        bcd_q, bcd_d;
  logic                 ovf_q, ovf_d;

  logic [DW-1:0]        adj;
  logic [DW-1:0]        scr_next;
  logic [63:0]          bin_ext;
  logic                 too_big;

  // Per-digit add-3 correction, no carry between digits.
  always_comb begin
    adj = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      adj[4*i +: 4] = add3(scr_q[4*i +: 4]);
    end
  end

  // Scratch after correction and one-bit shift; MSB falls off.
  always_comb begin
    scr_next = {adj[DW-2:0], sh_q[BIN_WIDTH-1]};
  end

  // Range check against the largest representable value.
  always_comb begin
    bin_ext = 64'(bus.BinaryIn);
    too_big = bin_ext > MAX_VAL;
  end

  // Next-state and datapath control for the IDLE/SHIFT sequencer.
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    scr_d      = scr_q;
    cnt_d      = cnt_q;
    ovf_flag_d = ovf_flag_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.Start) begin
          sh_d       = bus.BinaryIn;
          scr_d      = '0;
          cnt_d      = '0;
          ovf_flag_d = too_big;
          busy_d     = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        scr_d = scr_next;
        sh_d  = {sh_q[BIN_WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          bcd_d   = ovf_flag_q ? NINES : scr_next;
          ovf_d   = ovf_flag_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
    endcase
  end

  // State registers; reset aborts any conversion without a Done.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      scr_q      <= '0;
      cnt_q      <= '0;
      ovf_flag_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      scr_q      <= scr_d;
      cnt_q      <= cnt_d;
      ovf_flag_q <= ovf_flag_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
  assign bus.BcdOut   = bcd_q;
  assign bus.Overflow = ovf_q;

endmodule

// File: tb/tb_bcd_digit_encoder.sv
// Directed and randomized checks for the binary-to-BCD encoder.
// Inputs change and outputs are sampled 1ns after rising edges.
module tb_bcd_digit_encoder;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  logic [15:0] prev_bcd;
  logic        prev_ovf;

  bcd_digit_encoder_if #(.BIN_WIDTH(14), .NUM_DIGITS(4)) bus ();

  bcd_digit_encoder #(.BIN_WIDTH(14), .NUM_DIGITS(4)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    int d;
    d = (v > 9999) ? 9999 : v;
    return {4'(d / 1000), 4'((d / 100) % 10),
            4'((d / 10) % 10), 4'(d % 10)};
  endfunction

  // Run one conversion starting at the next edge.
  // poke >= 0 re-asserts Start (value 321) at edge E(poke+1).
  task automatic conv(input logic [13:0] v, input logic [15:0] eb,
                      input logic eo, input int poke,
                      input bit tail, input string tag);
    int cyc;
    int hold_bad;
    bus.Start    = 1'b1;
    bus.BinaryIn = v;
    @(posedge clk); #1;
    bus.Start    = 1'b0;
    bus.BinaryIn = 14'($urandom);
    chk({tag, " busy_after_E0"}, 32'(bus.Busy), 32'd1);
    cyc      = 0;
    hold_bad = 0;
    while (bus.Done !== 1'b1 && cyc < 40) begin
      if (cyc == poke) begin
        bus.Start    = 1'b1;
        bus.BinaryIn = 14'd321;
      end else begin
        bus.Start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (bus.Done !== 1'b1 &&
          (bus.BcdOut !== prev_bcd || bus.Overflow !== prev_ovf ||
           bus.Busy !== 1'b1))
        hold_bad++;
    end
    bus.Start = 1'b0;
    chk({tag, " latency"}, 32'(cyc), 32'd14);
    chk({tag, " hold"}, 32'(hold_bad), 32'd0);
    chk({tag, " bcd"}, 32'(bus.BcdOut), 32'(eb));
    chk({tag, " ovf"}, 32'(bus.Overflow), 32'(eo));
    chk({tag, " busy_at_done"}, 32'(bus.Busy), 32'd0);
    prev_bcd = eb;
    prev_ovf = eo;
    if (tail) begin
      @(posedge clk); #1;
      chk({tag, " done_single"}, 32'(bus.Done), 32'd0);
    end
  endtask

  initial begin
    int v;
    int gap;
    int dones;
    n_cmp        = 0;
    n_bad        = 0;
    prev_bcd     = 16'h0000;
    prev_ovf     = 1'b0;
    rst          = 1'b1;
    bus.Start    = 1'b0;
    bus.BinaryIn = '0;
    @(posedge clk); #1;
    chk("rst busy", 32'(bus.Busy), 32'd0);
    chk("rst done", 32'(bus.Done), 32'd0);
    chk("rst bcd", 32'(bus.BcdOut), 32'd0);
    chk("rst ovf", 32'(bus.Overflow), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle busy", 32'(bus.Busy), 32'd0);

    conv(14'd0, 16'h0000, 1'b0, -1, 1'b1, "zero");

    conv(14'd1234, 16'h1234, 1'b0, -1, 1'b1, "v1234");
    conv(14'd9999, 16'h9999, 1'b0, -1, 1'b1, "v9999");
    conv(14'd7, 16'h0007, 1'b0, -1, 1'b1, "v7");

    conv(14'd10000, 16'h9999, 1'b1, -1, 1'b1, "v10000");
    conv(14'd16383, 16'h9999, 1'b1, -1, 1'b1, "v16383");
    conv(14'd42, 16'h0042, 1'b0, -1, 1'b1, "v42");
    prev_bcd = 16'h0042;

    conv(14'd500, 16'h0500, 1'b0, 4, 1'b0, "busy_start");
    conv(14'd321, 16'h0321, 1'b0, -1, 1'b1, "b2b");
    conv(14'd42, 16'h0042, 1'b0, -1, 1'b1, "v42b");

    bus.Start    = 1'b1;
    bus.BinaryIn = 14'd888;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("abort busy_mid", 32'(bus.Busy), 32'd1);
    chk("abort bcd_hold", 32'(bus.BcdOut), 32'h0042);
    #2 rst = 1'b1;
    #1;
    chk("abort busy", 32'(bus.Busy), 32'd0);
    chk("abort done", 32'(bus.Done), 32'd0);
    chk("abort bcd", 32'(bus.BcdOut), 32'd0);
    chk("abort ovf", 32'(bus.Overflow), 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst   = 1'b0;
    dones = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.Done === 1'b1) dones++;
    end
    chk("abort no_done", 32'(dones), 32'd0);
    prev_bcd = 16'h0000;
    prev_ovf = 1'b0;
    conv(14'd888, 16'h0888, 1'b0, -1, 1'b1, "after_abort");

    for (int i = 0; i < 24; i++) begin
      v   = (i == 0) ? 9999 : (i == 1) ? 10000
          : int'($urandom_range(0, 16383));
      gap = int'($urandom_range(0, 3));
      dones = 0;
      repeat (gap) begin
        @(posedge clk); #1;
        if (bus.Done === 1'b1) dones++;
      end
      chk("rand gap_no_done", 32'(dones), 32'd0);
      conv(14'(v), to_bcd(v), v > 9999, -1, 1'b1, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_digit_encoder.md
Name: bcd_digit_encoder

Overview:
Sequential binary-to-BCD converter (shift-add-3, one bit per clock). It produces the per-digit 4-bit decimal nibbles that feed the seven-segment digit decoders. It sits between the chess-clock time counters (binary seconds) and the per-digit display decoders. A start/busy/done handshake lets the timer logic request a conversion whenever its count changes.

Parameters:
BIN_WIDTH, 14, width of the binary input; must be >= 4.
NUM_DIGITS, 4, number of BCD digits produced; the saturation limit is 10^NUM_DIGITS - 1.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
Start  input  1  conversion request; sampled only in IDLE.
BinaryIn  input  BIN_WIDTH  unsigned value; captured on the accepting edge only.
Busy  output  1  high while a conversion is in progress.
Done  output  1  single-cycle pulse when BcdOut/Overflow update.
BcdOut  output  4*NUM_DIGITS  result; digit 0 (units) in [3:0], digit i in [4i+3:4i].
Overflow  output  1  high if the last captured value exceeded 10^NUM_DIGITS - 1.

Behaviour:
- Reset (async, any time, including mid-conversion):
  - state=IDLE; Busy=0, Done=0, BcdOut=0, Overflow=0; internal shift/BCD registers and counter cleared.
  - No Done is issued for an aborted conversion.
- States: IDLE, SHIFT.
- IDLE:
  - Busy=0. If Start=1 at edge E0: capture BinaryIn into the shift register, clear the BCD scratch register, counter=0, go to SHIFT. Busy=1 after E0.
  - Also at E0, compare BinaryIn against MAX = 10^NUM_DIGITS - 1. Latch an internal overflow flag if BinaryIn > MAX.
- SHIFT, at each edge E1..E_BIN_WIDTH:
  - For every BCD scratch digit >= 5, add 3 (4-bit, no carry between digits).
  - Then shift the {scratch, shift register} pair left by 1. Counter increments.
- Completion, at edge E_BIN_WIDTH (the last iteration):
  - BcdOut <= final scratch value, or, if the overflow flag is set, all digits = 9.
  - Overflow <= overflow flag; Done <= 1 for exactly one cycle; Busy <= 0; return to IDLE.
- Latency: Start sampled at E0 → Done high in the cycle after E_BIN_WIDTH (BIN_WIDTH+1 edges). Throughput is one conversion per BIN_WIDTH+1 cycles.
- Start while Busy=1 is ignored; it is neither queued nor able to alter BinaryIn capture.
- Start=1 during the Done cycle (state already IDLE) is accepted normally, giving back-to-back conversions.
- BcdOut and Overflow hold the previous result for the whole conversion. They change only on the Done edge, so the display never shows intermediate scratch values.
- Done is never asserted two cycles in a row.
- BinaryIn changes after E0 have no effect.
- Width rules:
  - Scratch register is 4*NUM_DIGITS bits; bits shifted out of its MSB are discarded (overflow is handled by the compare, not by detection).
  - MAX is computed as a localparam at elaboration.

Test Plan:
1. Reset, then Start with BinaryIn=0 at E0 → Busy=1 for edges E0..E13; Done high only after E14; BcdOut=16'h0000; Overflow=0.
2. BinaryIn=1234 → BcdOut=16'h1234, Overflow=0. Then BinaryIn=9999 → 16'h9999, Overflow=0. Then BinaryIn=7 → 16'h0007.
3. BinaryIn=10000 → BcdOut=16'h9999, Overflow=1. Then BinaryIn=16383 → 16'h9999, Overflow=1. Next BinaryIn=42 → 16'h0042, Overflow=0.
4. Start with 500, then pulse Start with 321 at E5 while Busy → single Done, BcdOut=16'h0500. Start asserted in the Done cycle with 321 → second Done exactly 15 cycles later, BcdOut=16'h0321.
5. Start with 888 after a prior result of 16'h0042; assert reset at E7 → Busy, Done, BcdOut, Overflow all 0 immediately (asynchronously). No Done follows. A new Start after reset release converts correctly.
6. Random sweep of 0..16383 with random Start gaps → BcdOut matches the decimal digits of min(value, 9999), Overflow = (value > 9999), exactly one Done per accepted Start.
